// File: rtl/pipe_flow_ctrl.sv
// Drives stall/en into the 5-stage pipeline tracker and decodes its stage-state
// bus into occupancy, a saturating retire count and a sticky illegal-code flag.
module pipe_flow_ctrl #(
  parameter int STALL_CYCLES = 2,
  parameter int DRAIN_CYCLES = 5,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [14:0]      state_flat,
  input  logic             start,
  input  logic             halt_req,
  input  logic             hazard,
  output logic             stall,
  output logic             en,
  output logic             busy,
  output logic [2:0]       occupancy,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             illegal,
  output logic [2:0]       fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_RUN   = 3'b001,
    S_STALL = 3'b010,
    S_DRAIN = 3'b011,
    S_HALT  = 3'b100
  } state_t;

  localparam logic [3:0]       STALL_LOAD = 4'(STALL_CYCLES - 1);
  localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [3:0]       r_stall_cnt;
  logic [3:0]       r_drain_cnt;
  logic             r_halt_pend;
  logic             r_stall;
  logic             r_en;
  logic             r_busy;
  logic [2:0]       r_occupancy;
  logic [CNT_W-1:0] r_retire_cnt;
  logic             r_illegal;

  logic [2:0]       w_occ;
  logic             w_ill;
  logic             w_retire;

  // Outputs are computed from the next state so they line up with fsm_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_stall_cnt <= 4'd0;
      r_drain_cnt <= 4'd0;
      r_halt_pend <= 1'b0;
      r_stall     <= 1'b0;
      r_en        <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_state <= S_RUN;
            r_en    <= 1'b1;
            r_stall <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (halt_req) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= DRAIN_LOAD;
            r_halt_pend <= 1'b0;
          end else if (hazard) begin
            r_state     <= S_STALL;
            r_stall_cnt <= STALL_LOAD;
            r_stall     <= 1'b1;
          end
        end
        S_STALL: begin
          if (halt_req) begin
            r_halt_pend <= 1'b1;
          end
          if (r_stall_cnt == 4'd0) begin
            r_stall <= 1'b0;
            if (r_halt_pend || halt_req) begin
              r_state     <= S_DRAIN;
              r_drain_cnt <= DRAIN_LOAD;
              r_halt_pend <= 1'b0;
            end else begin
              r_state <= S_RUN;
            end
          end else begin
            r_stall_cnt <= r_stall_cnt - 4'd1;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == 4'd0) begin
            r_state <= S_HALT;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_drain_cnt <= r_drain_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_stall <= 1'b0;
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_occ = 3'd0;
    w_ill = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (state_flat[3*i +: 3] != 3'b111) begin
        w_occ = w_occ + 3'd1;
      end
      if ((state_flat[3*i +: 3] == 3'b101) || (state_flat[3*i +: 3] == 3'b110)) begin
        w_ill = 1'b1;
      end
    end
  end

  // A retirement is the last stage holding WB while the tracker actually advances.
  assign w_retire = r_en && !r_stall && (state_flat[14:12] == 3'b100);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occupancy  <= 3'd0;
      r_retire_cnt <= '0;
      r_illegal    <= 1'b0;
    end else begin
      r_occupancy <= w_occ;
      r_illegal   <= r_illegal | w_ill;
      if (w_retire && (r_retire_cnt != CNT_MAX)) begin
        r_retire_cnt <= r_retire_cnt + CNT_ONE;
      end
    end
  end

  assign stall      = r_stall;
  assign en         = r_en;
  assign busy       = r_busy;
  assign occupancy  = r_occupancy;
  assign retire_cnt = r_retire_cnt;
  assign illegal    = r_illegal;
  assign fsm_state  = r_state;

endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
- Controller on the driving side of the 5-stage pipeline state tracker. It generates the tracker's stall and en inputs.
- It decodes the tracker's flattened 15-bit stage-state bus (state_flat) to report occupancy, count retirements and flag illegal codes.
- A small FSM sequences start, hazard stalls, drain and halt.

Parameters:
STALL_CYCLES, 2, stall pulse length in cycles per hazard; legal range 1..15.
DRAIN_CYCLES, 5, number of advance cycles before halting (pipeline depth); legal range 1..15.
CNT_W, 16, width of retire counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
state_flat  in  15  stage codes {s4,s3,s2,s1,s0}, 3 bits each; IF=000 ID=001 EX=010 MEM=011 WB=100 NOP=111
start  in  1  begin/resume execution (level, sampled)
halt_req  in  1  request orderly drain then halt
hazard  in  1  hazard detected by decode, one-cycle pulse
stall  out  1  to tracker: hold stages
en  out  1  to tracker: enable advance
busy  out  1  FSM in RUN, STALL or DRAIN
occupancy  out  3  count of non-NOP stages, 0..5
retire_cnt  out  CNT_W  stage-4 WB advances, saturating
illegal  out  1  sticky: code 101 or 110 observed in any field
fsm_state  out  3  IDLE=000 RUN=001 STALL=010 DRAIN=011 HALT=100

Behaviour:
Decided interface:
- One clock.
- Reset is asynchronous and active-high.
- Ports are named clk and rst.

Reset values:
- All outputs are registered.
- rst=1 immediately forces stall=0, en=0, busy=0, occupancy=0, retire_cnt=0, illegal=0, fsm_state=IDLE.
- Internal stall/drain counters and halt_pend are cleared to 0.

FSM (next-state evaluated each posedge; outputs follow state):
- IDLE: en=0, stall=0. start=1 -> RUN.
- RUN: en=1, stall=0.
  - halt_req=1 -> DRAIN. halt_req has priority over a simultaneous hazard; that hazard is dropped.
  - else hazard=1 -> STALL, counter loads STALL_CYCLES-1.
- STALL: en=1, stall=1. stall stays high for exactly STALL_CYCLES consecutive cycles.
  - The counter decrements each cycle.
  - At counter=0, go to DRAIN if halt_pend, else RUN.
  - halt_req seen in STALL sets halt_pend; halt_pend clears on entering DRAIN.
  - hazard in STALL is ignored: no extension, no queueing.
- DRAIN: en=1, stall=0 for exactly DRAIN_CYCLES cycles, then HALT.
  - hazard and halt_req are ignored.
- HALT: en=0, stall=0. start=1 -> RUN. start is ignored in all other states.
- busy=1 only in RUN, STALL and DRAIN.

Decode (registered, one-cycle latency from state_flat):
- occupancy = number of 3-bit fields != 111.
- illegal sets when any field equals 101 or 110. It clears only on rst.
- retire_cnt increments when the registered en=1, stall=0 and state_flat[14:12]=100 at the same posedge.
  - It saturates at 2^CNT_W-1; no wrap.
  - It holds during STALL, IDLE and HALT.

Boundaries:
- rst asserted mid-STALL or mid-DRAIN aborts immediately to IDLE.
- After rst deasserts, the next transition requires start.

Test Plan:
- Reset then start=1 one cycle -> en=1 on the following cycle; fsm_state=001, busy=1, stall=0.
- RUN, hazard pulse (STALL_CYCLES=2) -> stall=1 for exactly 2 cycles, then RUN; a second hazard during the stall does not lengthen it.
- hazard and halt_req in the same RUN cycle -> DRAIN (011) with stall never asserted; en=1 for 5 cycles, then HALT with en=0, busy=0; start then returns to RUN.
- state_flat = {100,011,010,001,000} held 3 advancing cycles -> retire_cnt=3, occupancy=5; with CNT_W=2 and 5 WB advances, retire_cnt stays at 3.
- state_flat field value 110 for one cycle -> illegal=1 and stays 1 after the code clears, until rst.
- rst asserted asynchronously mid-STALL (between clock edges) -> stall=0, en=0, fsm_state=IDLE immediately, without a clock edge.
